// File: rtl/seq_frame_sched_if.sv
// seq_frame_sched_if
//   Host-side bundle for seq_frame_sched: frame word request channel
//   (in_valid / in_ready / in_data) and per-frame result channel
//   (res_valid / res_ready / res_count / res_hit / res_pos).
//   master : host side (drives requests, accepts results)
//   slave  : scheduler side
interface seq_frame_sched_if #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = $clog2(WORD_W + 1),
    parameter int unsigned POS_W  = $clog2(WORD_W)
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              res_valid;
    logic              res_ready;
    logic [CNT_W-1:0]  res_count;
    logic              res_hit;
    logic [POS_W-1:0]  res_pos;

    modport master (
        output in_valid, in_data, res_ready,
        input  in_ready, res_valid, res_count, res_hit, res_pos
    );

    modport slave (
        input  in_valid, in_data, res_ready,
        output in_ready, res_valid, res_count, res_hit, res_pos
    );
endinterface

// File: rtl/seq_frame_sched.sv
// seq_frame_sched
//   Sequences one bit-serial sequence detector. A host word is accepted,
//   the detector is cleared for one cycle, the word is shifted out MSB-first
//   one bit per clock, detector responses are counted (with the index of the
//   first hit) and a per-frame result is offered back to the host.
// Ports:
//   clock, reset : single clock, synchronous active-high reset
//   host         : seq_frame_sched_if.slave (frame request + result channel)
//   ser_out      : serial bit to detector
//   ser_valid    : ser_out carries a frame bit
//   det_clr      : detector clear (CLR state or reset)
//   det_in       : detector response, DET_LAT clocks after the driven bit
//   busy         : any state other than IDLE
module seq_frame_sched #(
    parameter int unsigned WORD_W  = 8,
    parameter int unsigned DET_LAT = 1,
    parameter int unsigned CNT_W   = $clog2(WORD_W + 1),
    parameter int unsigned POS_W   = $clog2(WORD_W)
) (
    input  logic             clock,
    input  logic             reset,
    seq_frame_sched_if.slave host,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             det_clr,
    input  logic             det_in,
    output logic             busy
);
    typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, REPORT} state_t;

    localparam logic [POS_W-1:0] LAST_K = POS_W'(WORD_W - 1);
    localparam logic [1:0]       LAST_D = 2'((DET_LAT > 0) ? DET_LAT - 1 : 0);

    state_t            state;
    state_t            state_nx;
    logic [WORD_W-1:0] sreg;
    logic [POS_W-1:0]  bit_k;
    logic [1:0]        drain_k;
    logic [CNT_W-1:0]  cnt;
    logic              hit;
    logic [POS_W-1:0]  pos;
    logic              accept;
    logic              samp_v;
    logic [POS_W-1:0]  samp_k;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        host.in_ready  = 1'b0;
        host.res_valid = 1'b0;
        ser_valid      = 1'b0;
        ser_out        = 1'b0;
        det_clr        = reset;
        busy           = 1'b1;
        accept         = 1'b0;
        case (state)
            IDLE: begin
                busy          = 1'b0;
                host.in_ready = !reset;
                accept        = host.in_valid && !reset;
                if (accept) state_nx = CLR;
            end
            CLR: begin
                det_clr  = 1'b1;
                state_nx = SHIFT;
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = sreg[WORD_W-1];
                if (bit_k == LAST_K) state_nx = (DET_LAT > 0) ? DRAIN : REPORT;
            end
            DRAIN: begin
                if (drain_k == LAST_D) state_nx = REPORT;
            end
            REPORT: begin
                host.res_valid = 1'b1;
                if (host.res_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Bit index travels alongside the "bit was driven" flag so that each
    // detector response is attributed to the bit that caused it.
    generate
        if (DET_LAT == 0) begin : g_nolat
            assign samp_v = (state == SHIFT);
            assign samp_k = bit_k;
        end else begin : g_lat
            logic             dv [DET_LAT];
            logic [POS_W-1:0] dk [DET_LAT];

            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int unsigned i = 0; i < DET_LAT; i++) begin
                        dv[i] <= 1'b0;
                        dk[i] <= '0;
                    end
                end else begin
                    dv[0] <= (state == SHIFT);
                    dk[0] <= bit_k;
                    for (int unsigned i = 1; i < DET_LAT; i++) begin
                        dv[i] <= dv[i-1];
                        dk[i] <= dk[i-1];
                    end
                end
            end

            assign samp_v = dv[DET_LAT-1];
            assign samp_k = dk[DET_LAT-1];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            sreg    <= '0;
            bit_k   <= '0;
            drain_k <= '0;
            cnt     <= '0;
            hit     <= 1'b0;
            pos     <= '0;
        end else begin
            if (state == SHIFT) begin
                sreg  <= {sreg[WORD_W-2:0], 1'b0};
                bit_k <= bit_k + 1'b1;
            end
            if (state == DRAIN) drain_k <= drain_k + 2'd1;
            if (samp_v && det_in) begin
                cnt <= cnt + 1'b1;
                if (!hit) begin
                    hit <= 1'b1;
                    pos <= samp_k;
                end
            end
            if (accept) begin
                sreg    <= host.in_data;
                bit_k   <= '0;
                drain_k <= '0;
                cnt     <= '0;
                hit     <= 1'b0;
                pos     <= '0;
            end
        end
    end

    assign host.res_count = cnt;
    assign host.res_hit   = hit;
    assign host.res_pos   = pos;
endmodule

// File: doc/seq_frame_sched.md
Name: seq_frame_sched

Overview:
- Controller that sequences the serial sequence-detector datapath (bit-serial input, single-bit detect output).
- Accepts a parallel word from a host via valid/ready and clears the detector at frame start.
- Shifts the word into the detector MSB-first, one bit per clock, then counts detector hits and records the position of the first hit.
- Returns a per-frame result via valid/ready. Sits between a host/register interface and one detector instance.

Parameters:
- WORD_W, 8: frame length in bits; legal range 2..64.
- DET_LAT, 1: clocks from a bit being driven on ser_out to its detect response on det_in; legal range 0..3.
- CNT_W, $clog2(WORD_W+1): width of the hit count.
- POS_W, $clog2(WORD_W): width of the first-hit position.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  host frame word valid.
- in_ready  out  1  block can accept a frame.
- in_data  in  WORD_W  frame word; bit WORD_W-1 is sent first.
- ser_out  out  1  serial bit to the detector's sequence input.
- ser_valid  out  1  high while ser_out carries a frame bit.
- det_clr  out  1  detector reset, active-high.
- det_in  in  1  detector output.
- res_valid  out  1  result available.
- res_ready  in  1  host accepts the result.
- res_count  out  CNT_W  number of hits in the frame.
- res_hit  out  1  at least one hit occurred.
- res_pos  out  POS_W  bit index k (0 = first bit sent) of the first hit; 0 when res_hit=0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- The clock and reset ports are named clock and reset. There is one clock. Reset is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - in_ready=0 during reset, and 1 from the first cycle after reset deasserts.
  - ser_out=0, ser_valid=0, res_valid=0, res_count=0, res_hit=0, res_pos=0, busy=0.
  - det_clr=1 while reset is high.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, load in_data into the shift register, clear the counters, and go to CLR.
  - CLR: one cycle with det_clr=1 and ser_valid=0. Go to SHIFT.
  - SHIFT: exactly WORD_W cycles. In cycle k (k=0..WORD_W-1), ser_out = in_data[WORD_W-1-k] and ser_valid=1. The shift register moves left each cycle. After the last bit, go to DRAIN if DET_LAT>0, else go to REPORT.
  - DRAIN: DET_LAT cycles with ser_valid=0 and ser_out=0. Go to REPORT.
  - REPORT: res_valid=1 and the res_* outputs are held stable. On res_ready, go to IDLE next cycle and drop res_valid.
- Sampling rule: det_in observed in the cycle DET_LAT cycles after SHIFT cycle k belongs to bit k. Only these WORD_W samples are counted. det_in in all other cycles is ignored.
  - On each counted sample with det_in=1: res_count increments.
  - If res_hit was 0, res_hit is set and res_pos is set to k.
- res_count cannot overflow, since its maximum is WORD_W.
- Latency: accept in cycle T puts CLR in T+1 and SHIFT in T+2..T+1+WORD_W. res_valid first rises at T+2+WORD_W+DET_LAT.
- in_valid while not in IDLE is ignored; in_data is not sampled.
- res_ready while res_valid=0 is ignored.
- res_ready in the first REPORT cycle gives a one-cycle res_valid pulse. Back-to-back frames are spaced at minimum WORD_W+DET_LAT+3 cycles.
- det_clr is high only in CLR or during reset.
- Reset asserted in any state aborts the frame: the result is discarded and every output takes its reset value the next cycle.

Test Plan:
- Bench detector model: overlapping "1011" detector, registered output, DET_LAT=1. WORD_W=8 unless noted.
1. Reset, then in_data=8'b1011_1011 accepted at cycle T -> det_clr pulse at T+1, and ser_out=1,0,1,1,1,0,1,1 at T+2..T+9. res_valid rises at T+11 with res_count=2, res_hit=1, res_pos=3.
2. in_data=8'b1011_0110 -> res_count=2 (overlap, hits at k=3 and k=6), res_pos=3.
3. in_data=8'h00 -> res_count=0, res_hit=0, res_pos=0. det_in forced to 1 during CLR and after DRAIN is not counted.
4. res_ready held low 5 cycles after res_valid -> res outputs stable and in_ready=0 throughout. in_valid pulses are ignored; the next frame is accepted only after the res_ready handshake.
5. reset asserted mid-SHIFT (k=4) -> next cycle busy=0, ser_valid=0, res_valid=0, and det_clr=1 while reset is high. A fresh frame then completes correctly.
6. DET_LAT=0 and WORD_W=4 with a combinational "1011" model, in_data=4'b1011 -> no DRAIN state, res_valid at T+6, res_count=1, res_pos=3.
